mem_resp_queue: RTL and testbench

Parametrised memory-stage response tracker that replaces the single-entry load/store wait in the MEM pipeline stage. It records up to DEPTH in-flight data-SRAM requests issued by EX and matches in-order `data_ok` responses to them. It formats load data (ld.w/b/bu/h/hu) and hands completed instructions to WB through a valid/ready handshake. On pipeline flush it drops queued entries and silently discards the late responses that belong to them.

---
 rtl/mem_resp_queue.sv | 172 +++++++++++++++++
 tb/tb_mem_resp_queue.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_queue.sv
// rtl/mem_resp_queue.sv - in-order MEM-stage response tracker with load formatting and flush discard
// Optional same-cycle response bypass to WB: define MEM_RESP_BYPASS_EN.
module mem_resp_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_load,
  input  logic [4:0]       req_ld_op,
  input  logic [1:0]       req_offset,
  input  logic [4:0]       req_dest,
  input  logic [31:0]      req_pc,
  input  logic             data_ok,
  input  logic [31:0]      rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [4:0]       out_dest,
  output logic             out_is_load,
  output logic [31:0]      out_result,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] discard_cnt,
  output logic             proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = CNT_W + 1;

  logic [31:0]      pc_q     [DEPTH];
  logic [4:0]       dest_q   [DEPTH];
  logic             is_ld_q  [DEPTH];
  logic [4:0]       ld_op_q  [DEPTH];
  logic [1:0]       offset_q [DEPTH];
  logic [31:0]      data_q   [DEPTH];
  logic [DEPTH-1:0] valid_q, done_q;

  logic [PTR_W-1:0] head_q, head_d, resp_q, resp_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, discard_q, discard_d, pend;
  logic             perr_q, perr_d;
  logic             push, pop, drop, resp_hit, bypass_hit;
  logic [SUM_W-1:0] occ;
  logic [31:0]      head_data;

  function automatic logic [31:0] fmt_load(input logic [4:0] op, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (op)
      5'b00001: fmt_load = d;
      5'b00010: fmt_load = {{24{b[7]}}, b};
      5'b00100: fmt_load = {24'd0, b};
      5'b01000: fmt_load = {{16{h[15]}}, h};
      5'b10000: fmt_load = {16'd0, h};
      default:  fmt_load = 32'd0;
    endcase
  endfunction

  assign occ       = {1'b0, count_q} + {1'b0, discard_q};
  assign req_ready = occ < SUM_W'(DEPTH);
  assign push      = req_valid && req_ready && !flush;
  assign drop      = data_ok && (discard_q != '0);
  assign resp_hit  = data_ok && (discard_q == '0) && valid_q[resp_q] && !done_q[resp_q];

`ifdef MEM_RESP_BYPASS_EN
  assign bypass_hit = resp_hit && (resp_q == head_q);
`else
  assign bypass_hit = 1'b0;
`endif

  assign out_valid   = !flush && valid_q[head_q] && (done_q[head_q] || bypass_hit);
  assign pop         = out_valid && out_ready;
  assign head_data   = done_q[head_q] ? data_q[head_q] : rdata;
  assign out_pc      = valid_q[head_q] ? pc_q[head_q] : 32'd0;
  assign out_dest    = valid_q[head_q] ? dest_q[head_q] : 5'd0;
  assign out_is_load = valid_q[head_q] && is_ld_q[head_q];
  assign out_result  = (out_valid && is_ld_q[head_q]) ?
                       fmt_load(ld_op_q[head_q], offset_q[head_q], head_data) : 32'd0;
  assign count       = count_q;
  assign discard_cnt = discard_q;
  assign proto_err   = perr_q;

  // Entries still waiting for their response become debts on flush.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !done_q[i]) pend = pend + CNT_W'(1);
    end
  end

  always_comb begin
    head_d    = head_q;
    resp_d    = resp_q;
    tail_d    = tail_q;
    count_d   = count_q;
    discard_d = discard_q - CNT_W'(drop);
    perr_d    = perr_q || (req_valid && !req_ready) || (data_ok && !drop && !resp_hit);
    if (flush) begin
      head_d    = '0;
      resp_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      discard_d = discard_q + pend + CNT_W'(req_valid) - CNT_W'(resp_hit) - CNT_W'(drop);
    end else begin
      if (resp_hit) resp_d = resp_q + PTR_W'(1);
      if (pop)      head_d = head_q + PTR_W'(1);
      if (push)     tail_d = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q    <= '0;
      resp_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      discard_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      head_q    <= head_d;
      resp_q    <= resp_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      perr_q    <= perr_d;
    end
  end

  // Pop clears after the response write so a bypassed entry leaves without done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      done_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]     <= 32'd0;
        dest_q[i]   <= 5'd0;
        is_ld_q[i]  <= 1'b0;
        ld_op_q[i]  <= 5'd0;
        offset_q[i] <= 2'd0;
        data_q[i]   <= 32'd0;
      end
    end else if (flush) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (resp_hit) begin
        done_q[resp_q] <= 1'b1;
        data_q[resp_q] <= rdata;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
      end
      if (push) begin
        valid_q[tail_q]  <= 1'b1;
        done_q[tail_q]   <= 1'b0;
        pc_q[tail_q]     <= req_pc;
        dest_q[tail_q]   <= req_dest;
        is_ld_q[tail_q]  <= req_is_load;
        ld_op_q[tail_q]  <= req_ld_op;
        offset_q[tail_q] <= req_offset;
      end
    end
  end

endmodule

// File: tb/tb_mem_resp_queue.sv
// tb/tb_mem_resp_queue.sv - self-checking bench for mem_resp_queue against a queue-based model
module tb_mem_resp_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef MEM_RESP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn, flush, req_valid, req_ready, req_is_load, data_ok, out_valid, out_ready;
  logic out_is_load, proto_err;
  logic [4:0] req_ld_op, req_dest, out_dest;
  logic [1:0] req_offset;
  logic [31:0] req_pc, rdata, out_pc, out_result;
  logic [CNT_W-1:0] count, discard_cnt;

  always #5 clk = ~clk;

  mem_resp_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_ld_op(req_ld_op), .req_offset(req_offset),
    .req_dest(req_dest), .req_pc(req_pc), .data_ok(data_ok), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_dest(out_dest),
    .out_is_load(out_is_load), .out_result(out_result), .count(count),
    .discard_cnt(discard_cnt), .proto_err(proto_err));

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        ld;
    logic [4:0]  op;
    logic [1:0]  off;
    logic        done;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   mdisc;
  bit   mperr;
  int   n_cmp = 0, n_bad = 0;
  logic e_valid, e_ready, e_hit, e_isld;
  logic [31:0] e_result, e_pc;
  logic [4:0]  e_dest;
  int   e_idx;

  function automatic logic [31:0] m_fmt(input logic [4:0] op, input logic [1:0] off,
                                        input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    int v;
    b = 8'(d >> (off * 8));
    h = (off >= 2) ? d[31:16] : d[15:0];
    if (op == 5'b00001) return d;
    if (op == 5'b00010) begin v = $signed(b); return 32'(v); end
    if (op == 5'b00100) return 32'(b);
    if (op == 5'b01000) begin v = $signed(h); return 32'(v); end
    if (op == 5'b10000) return 32'(h);
    return 32'd0;
  endfunction

  task automatic eval();
    e_idx = -1;
    foreach (mq[i]) if (!mq[i].done && e_idx < 0) e_idx = i;
    e_ready  = (mq.size() + mdisc) < DEPTH;
    e_hit    = data_ok && (mdisc == 0) && (e_idx >= 0);
    e_valid  = !flush && (mq.size() > 0) && (mq[0].done || (BYP && e_hit && e_idx == 0));
    e_pc = 0; e_dest = 0; e_isld = 0; e_result = 0;
    if (mq.size() > 0) begin
      e_pc = mq[0].pc; e_dest = mq[0].dest; e_isld = mq[0].ld;
      if (e_valid && mq[0].ld)
        e_result = m_fmt(mq[0].op, mq[0].off, mq[0].done ? mq[0].data : rdata);
    end
  endtask

  task automatic m_update();
    int nd;
    ent_t e;
    eval();
    if (req_valid && !e_ready) mperr = 1;
    if (data_ok && mdisc == 0 && !e_hit) mperr = 1;
    if (flush) begin
      nd = 0;
      foreach (mq[i]) if (!mq[i].done) nd++;
      mdisc = mdisc + nd - int'(e_hit) + int'(req_valid) - ((data_ok && mdisc > 0) ? 1 : 0);
      mq.delete();
    end else begin
      if (data_ok && mdisc > 0) mdisc--;
      else if (e_hit) begin mq[e_idx].done = 1; mq[e_idx].data = rdata; end
      if (e_valid && out_ready) void'(mq.pop_front());
      if (req_valid && e_ready) begin
        e.pc = req_pc; e.dest = req_dest; e.ld = req_is_load; e.op = req_ld_op;
        e.off = req_offset; e.done = 0; e.data = 0;
        mq.push_back(e);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 0; data_ok = 0; out_ready = 0; flush = 0; req_is_load = 0;
    req_ld_op = 0; req_offset = 0; req_dest = 0; req_pc = 0; rdata = 0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 0;
    mq.delete(); mdisc = 0; mperr = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  task automatic push(input logic ld, input logic [4:0] op, input logic [1:0] off,
                      input logic [4:0] dst, input logic [31:0] pc);
    req_valid = 1; req_is_load = ld; req_ld_op = op; req_offset = off;
    req_dest = dst; req_pc = pc;
    adv();
    req_valid = 0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 0;
    mq.delete(); mdisc = 0; mperr = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_hs valid=%b ready=%b exp 0/1", out_valid, req_ready); end
    n_cmp++; if (count !== '0 || discard_cnt !== '0 || proto_err !== 1'b0) begin n_bad++;
      $display("FAIL reset_cnt count=%0d disc=%0d perr=%b exp 0/0/0", count, discard_cnt, proto_err); end
    n_cmp++; if (out_pc !== 0 || out_dest !== 0 || out_is_load !== 0 || out_result !== 0) begin n_bad++;
      $display("FAIL reset_out pc=%h dest=%0d ld=%b res=%h exp zeros", out_pc, out_dest, out_is_load, out_result); end
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_load_byte();
    push(1, 5'b00010, 2'd2, 5'd3, 32'h0000_1000);
    data_ok = 1; rdata = 32'h0080_FF00;
    #1;
    n_cmp++; if (out_valid !== BYP || out_result !== (BYP ? 32'hFFFF_FF80 : 32'd0)) begin n_bad++;
      $display("FAIL ldb_rsp_cycle valid=%b res=%h exp valid=%b", out_valid, out_result, BYP); end
    adv();
    data_ok = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FF80 || out_dest !== 5'd3) begin n_bad++;
      $display("FAIL ldb_result valid=%b res=%h dest=%0d exp 1/ffffff80/3", out_valid, out_result, out_dest); end
    out_ready = 1;
    adv();
    out_ready = 0;
    #1;
    n_cmp++; if (count !== '0 || out_valid !== 1'b0) begin n_bad++;
      $display("FAIL ldb_pop count=%0d valid=%b exp 0/0", count, out_valid); end
  endtask

  task automatic test_hu_store();
    push(1, 5'b10000, 2'd2, 5'd7, 32'h0000_2000);
    push(0, 5'b00001, 2'd0, 5'd0, 32'h0000_2004);
    data_ok = 1; rdata = 32'h8001_1234;
    adv();
    rdata = 32'hDEAD_BEEF; out_ready = 1;
    #1;
    n_cmp++; if (out_result !== 32'h0000_8001 || out_is_load !== 1'b1) begin n_bad++;
      $display("FAIL ldhu res=%h ld=%b exp 00008001/1", out_result, out_is_load); end
    adv();
    data_ok = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_is_load !== 1'b0 || out_result !== 32'd0 || out_pc !== 32'h2004) begin n_bad++;
      $display("FAIL store valid=%b ld=%b res=%h pc=%h exp 1/0/0/2004", out_valid, out_is_load, out_result, out_pc); end
    adv();
    out_ready = 0;
    #1;
    n_cmp++; if (count !== '0) begin n_bad++;
      $display("FAIL store_pop count=%0d exp 0", count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) push(1, 5'b00001, 2'd0, 5'(i + 1), 32'h3000 + 32'(4 * i));
    #1;
    n_cmp++; if (req_ready !== 1'b0 || count !== CNT_W'(DEPTH)) begin n_bad++;
      $display("FAIL full ready=%b count=%0d exp 0/%0d", req_ready, count, DEPTH); end
    for (int i = 1; i <= DEPTH; i++) begin
      data_ok = 1; rdata = 32'(i);
      adv();
    end
    data_ok = 0; out_ready = 1;
    #1;
    n_cmp++; if (out_result !== 32'd1 || req_ready !== 1'b0) begin n_bad++;
      $display("FAIL full_first res=%h ready=%b exp 1/0", out_result, req_ready); end
    adv();
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++;
      $display("FAIL full_reopen ready=%b exp 1", req_ready); end
    for (int i = 2; i <= DEPTH; i++) begin
      n_cmp++; if (out_result !== 32'(i) || out_valid !== 1'b1) begin n_bad++;
        $display("FAIL full_order idx=%0d res=%h valid=%b exp %0d/1", i, out_result, out_valid, i); end
      adv();
      #1;
    end
    out_ready = 0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push(1, 5'b00001, 2'd0, 5'd9, 32'h4000 + 32'(4 * i));
    data_ok = 1; rdata = 32'h55;
    adv();
    data_ok = 0; flush = 1; req_valid = 1; req_pc = 32'h4100;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL flush_valid valid=%b exp 0", out_valid); end
    adv();
    flush = 0; req_valid = 0;
    #1;
    n_cmp++; if (count !== '0 || discard_cnt !== CNT_W'(3)) begin n_bad++;
      $display("FAIL flush_cnt count=%0d disc=%0d exp 0/3", count, discard_cnt); end
    for (int k = 1; k <= 3; k++) begin
      data_ok = 1; rdata = $urandom;
      adv();
      data_ok = 0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || discard_cnt !== CNT_W'(3 - k)) begin n_bad++;
        $display("FAIL flush_drop k=%0d valid=%b disc=%0d exp 0/%0d", k, out_valid, discard_cnt, 3 - k); end
    end
    n_cmp++; if (proto_err !== 1'b0) begin n_bad++;
      $display("FAIL flush_perr perr=%b exp 0", proto_err); end
  endtask

  task automatic test_random();
    int pend;
    for (int c = 0; c < 500; c++) begin
      pend = 0;
      foreach (mq[i]) if (!mq[i].done) pend++;
      flush       = ($urandom % 20) == 0;
      req_valid   = (($urandom % 2) == 0) && ((mq.size() + mdisc) < DEPTH);
      req_is_load = ($urandom % 4) != 0;
      case ($urandom % 7)
        0, 1, 2, 3, 4: req_ld_op = 5'(1 << ($urandom % 5));
        5:             req_ld_op = 5'b00000;
        default:       req_ld_op = 5'b00110;
      endcase
      req_offset = 2'($urandom); req_dest = 5'($urandom); req_pc = $urandom;
      data_ok    = (pend > 0 || mdisc > 0) && (($urandom % 2) == 0);
      rdata      = $urandom;
      out_ready  = ($urandom % 3) != 0;
      #1;
      eval();
      n_cmp++; if (out_valid !== e_valid || req_ready !== e_ready) begin n_bad++;
        $display("FAIL rnd_hs cyc=%0d valid=%b ready=%b exp %b/%b", c, out_valid, req_ready, e_valid, e_ready); end
      n_cmp++; if (out_result !== e_result) begin n_bad++;
        $display("FAIL rnd_result cyc=%0d got %h exp %h", c, out_result, e_result); end
      n_cmp++; if (out_pc !== e_pc || out_dest !== e_dest || out_is_load !== e_isld) begin n_bad++;
        $display("FAIL rnd_head cyc=%0d pc=%h dest=%0d ld=%b exp %h/%0d/%b", c, out_pc, out_dest, out_is_load, e_pc, e_dest, e_isld); end
      n_cmp++; if (count !== CNT_W'(mq.size()) || discard_cnt !== CNT_W'(mdisc) || proto_err !== mperr) begin n_bad++;
        $display("FAIL rnd_state cyc=%0d count=%0d disc=%0d perr=%b exp %0d/%0d/%b", c, count, discard_cnt, proto_err, mq.size(), mdisc, mperr); end
      adv();
    end
    idle();
  endtask

  task automatic test_proto();
    do_reset();
    data_ok = 1; rdata = 32'h1234;
    adv();
    data_ok = 0;
    repeat (3) adv();
    #1;
    n_cmp++; if (proto_err !== 1'b1 || count !== '0 || discard_cnt !== '0) begin n_bad++;
      $display("FAIL proto perr=%b count=%0d disc=%0d exp 1/0/0", proto_err, count, discard_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(1, 5'b00001, 2'd0, 5'd1, 32'h5000);
    push(1, 5'b00001, 2'd0, 5'd2, 32'h5004);
    #2;
    resetn = 0;
    mq.delete(); mdisc = 0; mperr = 0;
    #1;
    n_cmp++; if (count !== '0 || req_ready !== 1'b1 || out_valid !== 1'b0 || out_pc !== 32'd0 || discard_cnt !== '0) begin n_bad++;
      $display("FAIL areset count=%0d ready=%b valid=%b pc=%h disc=%0d exp 0/1/0/0/0", count, req_ready, out_valid, out_pc, discard_cnt); end
    @(negedge clk);
    resetn = 1; data_ok = 1;
    adv();
    data_ok = 0;
    #1;
    n_cmp++; if (proto_err !== 1'b1) begin n_bad++;
      $display("FAIL areset_perr perr=%b exp 1", proto_err); end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_hu_store();
    test_full();
    test_flush();
    test_random();
    test_proto();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
